// File: rtl/button_conditioner.sv
// button_conditioner: conditions the raw mode-select and increment buttons.
// Each channel is synchronized by two flops, debounced by a counter, and
// turned into a single-cycle press pulse. The increment channel also
// auto-repeats while it is held.
// rpt_state exposes the repeat FSM state (0 = IDLE, 1 = WAIT, 2 = REPEAT).
module button_conditioner #(
    parameter int CLK_HZ          = 100_000_000,
    parameter int DEBOUNCE_MS     = 20,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100
) (
    input  logic       clk,
    input  logic       reset,        // asynchronous, active-low
    input  logic       btn_sel_raw,
    input  logic       btn_add_raw,
    output logic       sel_pulse,
    output logic       add_pulse,
    output logic       sel_level,
    output logic       add_level,
    output logic [1:0] rpt_state
);

    // Cycle counts derived from the clock rate. Each of them must be at least 2.
    localparam int DB_CYC  = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int DLY_CYC = CLK_HZ / 1000 * REPEAT_DELAY_MS;
    localparam int RPT_CYC = CLK_HZ / 1000 * REPEAT_RATE_MS;
    localparam int MAX_A   = (DB_CYC > DLY_CYC) ? DB_CYC : DLY_CYC;
    localparam int MAX_CYC = (MAX_A > RPT_CYC) ? MAX_A : RPT_CYC;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYC - 1);
    localparam logic [CW-1:0] DLY_LAST = CW'(DLY_CYC - 1);
    localparam logic [CW-1:0] RPT_LAST = CW'(RPT_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Repeat FSM encoding.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    // Channel 0 is sel, channel 1 is add.
    logic [1:0]    raw;
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    level_q;
    logic [1:0]    level_d;
    logic [1:0]    rise;
    logic [CW-1:0] db_cnt_q [2];
    logic [CW-1:0] db_cnt_d [2];

    logic          sel_pulse_q;
    logic          sel_pulse_d;
    logic          add_pulse_q;
    logic          add_pulse_d;
    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [CW-1:0] timer_q;
    logic [CW-1:0] timer_d;

    assign raw = {btn_add_raw, btn_sel_raw};

    // Debounce: the level follows sync only after DB_CYC consecutive
    // differing samples; any agreeing sample restarts the count.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            level_d[ch]  = level_q[ch];
            db_cnt_d[ch] = '0;
            if (sync2_q[ch] != level_q[ch]) begin
                if (db_cnt_q[ch] == DB_LAST) begin
                    level_d[ch] = sync2_q[ch];
                end else begin
                    db_cnt_d[ch] = db_cnt_q[ch] + CNT_ONE;
                end
            end
        end
    end

    // Press detection: the pulse is registered together with the level edge.
    assign rise        = level_d & ~level_q;
    assign sel_pulse_d = rise[0];

    // Repeat FSM for add: press pulse, hold delay, then periodic pulses.
    // A release seen in the same cycle as a due pulse suppresses that pulse.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        add_pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (rise[1]) begin
                    add_pulse_d = 1'b1;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!level_d[1]) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (timer_q == DLY_LAST) begin
                    add_pulse_d = 1'b1;
                    timer_d     = '0;
                    state_d     = ST_REPEAT;
                end else begin
                    timer_d = timer_q + CNT_ONE;
                end
            end
            ST_REPEAT: begin
                if (!level_d[1]) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (timer_q == RPT_LAST) begin
                    add_pulse_d = 1'b1;
                    timer_d     = '0;
                end else begin
                    timer_d = timer_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // State registers, all cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            level_q     <= '0;
            for (int ch = 0; ch < 2; ch++) begin
                db_cnt_q[ch] <= '0;
            end
            sel_pulse_q <= 1'b0;
            add_pulse_q <= 1'b0;
            state_q     <= ST_IDLE;
            timer_q     <= '0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            for (int ch = 0; ch < 2; ch++) begin
                db_cnt_q[ch] <= db_cnt_d[ch];
            end
            sel_pulse_q <= sel_pulse_d;
            add_pulse_q <= add_pulse_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
        end
    end

    assign sel_pulse = sel_pulse_q;
    assign add_pulse = add_pulse_q;
    assign sel_level = level_q[0];
    assign add_level = level_q[1];
    assign rpt_state = state_q;

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed bench for button_conditioner with the
// timing scaled down to DB_CYC=4, DLY_CYC=10, RPT_CYC=3. Step numbering:
// step k means the k-th rising edge after a stimulus change, with outputs
// sampled on the following falling edge. A raw step first sampled at step 1
// reaches the level (and the press pulse) at step 6.
module tb_button_conditioner;

  logic       clk;
  logic       reset;
  logic       btn_sel_raw;
  logic       btn_add_raw;
  logic       sel_pulse;
  logic       add_pulse;
  logic       sel_level;
  logic       add_level;
  logic [1:0] rpt_state;

  int tests_run;
  int tests_failed;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  logic [31:0] sel_obs[$];
  logic [31:0] add_obs[$];
  logic        sel_hist [0:127];
  logic        add_hist [0:127];
  int          consec_add;

  button_conditioner #(
    .CLK_HZ          (1000),
    .DEBOUNCE_MS     (4),
    .REPEAT_DELAY_MS (10),
    .REPEAT_RATE_MS  (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_sel_raw (btn_sel_raw),
    .btn_add_raw (btn_add_raw),
    .sel_pulse   (sel_pulse),
    .add_pulse   (add_pulse),
    .sel_level   (sel_level),
    .add_level   (add_level),
    .rpt_state   (rpt_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs n steps, recording pulse step numbers and level history. Raw inputs
  // are dropped after step sel_off / add_off (0 = leave unchanged).
  task automatic run_window(input int n, input int sel_off, input int add_off);
    logic add_prev;
    sel_obs.delete();
    add_obs.delete();
    consec_add = 0;
    add_prev = 1'b0;
    for (int i = 1; i <= n; i++) begin
      step();
      if (sel_pulse) sel_obs.push_back(i);
      if (add_pulse) add_obs.push_back(i);
      if (add_pulse && add_prev) consec_add++;
      add_prev = add_pulse;
      sel_hist[i] = sel_level;
      add_hist[i] = add_level;
      if (i == sel_off) btn_sel_raw = 1'b0;
      if (i == add_off) btn_add_raw = 1'b0;
    end
  endtask

  // scoreboard: compare observed pulse steps against the expected queue
  task automatic compare_q(input string tag);
    check_eq({tag, "_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      check_eq({tag, "_step"}, obs_q.pop_front(), exp_q.pop_front());
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic settle();
    btn_sel_raw = 1'b0;
    btn_add_raw = 1'b0;
    repeat (15) step();
  endtask

  initial begin
    int nz;
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    btn_sel_raw  = 1'b0;
    btn_add_raw  = 1'b0;

    // 1: reset state, then 50 idle cycles with everything low
    repeat (3) step();
    check_eq("rst_outputs", {27'd0, sel_pulse, add_pulse, sel_level, add_level, rpt_state}, 32'd0);
    reset = 1'b1;
    nz = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (sel_pulse || add_pulse || sel_level || add_level || rpt_state != 2'd0) nz++;
    end
    check_eq("idle_outputs", nz, 0);

    // 2: sel held 20 samples, then released
    btn_sel_raw = 1'b1;
    run_window(20, 20, 0);
    check_eq("sel_lvl_s5", sel_hist[5], 1'b0);
    check_eq("sel_lvl_s6", sel_hist[6], 1'b1);
    exp_q = {32'd6};
    obs_q = sel_obs;
    compare_q("sel_press");
    check_eq("sel_no_add", add_obs.size(), 0);
    run_window(10, 0, 0);
    check_eq("sel_rel_s5", sel_hist[5], 1'b1);
    check_eq("sel_rel_s6", sel_hist[6], 1'b0);
    check_eq("sel_rel_pulses", sel_obs.size(), 0);
    settle();

    // 3: glitches of 3 samples high, 1 low, 3 high: too short to debounce
    btn_sel_raw = 1'b1;
    repeat (3) step();
    btn_sel_raw = 1'b0;
    step();
    btn_sel_raw = 1'b1;
    repeat (3) step();
    btn_sel_raw = 1'b0;
    run_window(15, 0, 0);
    nz = 0;
    for (int i = 1; i <= 15; i++) if (sel_hist[i]) nz++;
    check_eq("glitch_level", nz, 0);
    check_eq("glitch_pulses", sel_obs.size(), 0);
    settle();

    // 4: add held 40 samples. Level is high steps 6..45, so the pulse due
    // at 46 coincides with the release and is suppressed.
    btn_add_raw = 1'b1;
    run_window(60, 0, 40);
    exp_q = {32'd6, 32'd16, 32'd19, 32'd22, 32'd25, 32'd28, 32'd31,
             32'd34, 32'd37, 32'd40, 32'd43};
    obs_q = add_obs;
    compare_q("add_hold");
    check_eq("add_hold_consec", consec_add, 0);
    check_eq("add_hold_lvl45", add_hist[45], 1'b1);
    check_eq("add_hold_lvl46", add_hist[46], 1'b0);
    check_eq("add_hold_idle", rpt_state, 2'd0);
    settle();

    // 5: add held 10 samples; level falls at step 16 exactly when the
    // first repeat pulse would fire, so only the press pulse appears.
    btn_add_raw = 1'b1;
    run_window(25, 0, 10);
    check_eq("add_edge_lvl15", add_hist[15], 1'b1);
    check_eq("add_edge_lvl16", add_hist[16], 1'b0);
    exp_q = {32'd6};
    obs_q = add_obs;
    compare_q("add_edge");
    check_eq("add_edge_idle", rpt_state, 2'd0);
    settle();

    // 6: both pressed together, both held 20 samples. Add level is high
    // steps 6..25: press at 6, repeats at 16, 19, 22, 25.
    btn_sel_raw = 1'b1;
    btn_add_raw = 1'b1;
    run_window(35, 20, 20);
    exp_q = {32'd6};
    obs_q = sel_obs;
    compare_q("both_sel");
    exp_q = {32'd6, 32'd16, 32'd19, 32'd22, 32'd25};
    obs_q = add_obs;
    compare_q("both_add");
    settle();

    // 7: asynchronous reset mid-hold, then re-debounce of the held button
    btn_add_raw = 1'b1;
    repeat (8) step();
    check_eq("midrst_pre_lvl", add_level, 1'b1);
    check_eq("midrst_pre_state", rpt_state, 2'd1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("midrst_lvl", add_level, 1'b0);
    check_eq("midrst_state", rpt_state, 2'd0);
    @(negedge clk);
    reset = 1'b1;
    run_window(10, 0, 0);
    check_eq("midrst_lvl_s5", add_hist[5], 1'b0);
    check_eq("midrst_lvl_s6", add_hist[6], 1'b1);
    exp_q = {32'd6};
    obs_q = add_obs;
    compare_q("midrst_press");
    settle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
